uart_core_p: RTL and testbench
==============================

# uart_core_p

Parametrised UART core, successor to the fixed 8N1 UART top. It integrates the baud tick generator, a 16x-oversampled receiver, a transmitter and two first-word-fall-through FIFOs of configurable depth. Word width, parity mode and stop-bit length are configurable. The core adds parity checking, framing and overrun detection with sticky error flags, glitch rejection on the start bit, and FIFO occupancy counts. It sits between the physical rx/tx pins and the host-side byte interface.

## Interface
Parameters:
- DBIT, 8, data bits per frame (5..9), sent LSB first
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- SB_TICK, 16, stop-bit length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- ADDR_W, 4, FIFO address width; depth = 2^ADDR_W per FIFO
- DIV_W, 16, width of the baud divisor

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- Final_Value  in  DIV_W  baud divisor; tick period = Final_Value+1 clocks
- rx  in  1  serial input, asynchronous, idles high
- tx  out  1  serial output, idles high
- wr_uart  in  1  push w_data into the TX FIFO
- w_data  in  DBIT  transmit word
- rd_uart  in  1  pop the RX FIFO head
- r_data  out  DBIT  RX FIFO head (FWFT); valid when rx_empty=0
- rx_empty, rx_full, tx_empty, tx_full  out  1 each  FIFO status
- rx_count, tx_count  out  ADDR_W+1 each  FIFO occupancy
- tx_busy  out  1  transmitter not IDLE
- clr_err  in  1  clears all sticky error flags
- parity_err, frame_err, overrun  out  1 each  sticky error flags

## Operation
- Reset values: tx=1, tx_busy=0, counts=0, rx_empty=tx_empty=1, rx_full=tx_full=0, all error flags 0, r_data=0, both FSMs IDLE, tick counter 0.
- Baud: the counter runs 0..Final_Value. tick is high for one clock when the counter equals Final_Value, then the counter returns to 0. A change to Final_Value takes effect on the next wrap.
- rx passes through a 2-flop synchroniser, reset value 1. All rx decisions use the synchronised signal.
- RX FSM (IDLE, START, DATA, PARITY, STOP); s = tick count, n = bit count:
  - IDLE→START when rx=0, with s=0.
  - START: at s=7, rx=0 → DATA (s=0, n=0); rx=1 → IDLE, the glitch is ignored.
  - DATA: at s=15, sample rx into the shift register MSB and shift right. After DBIT samples, go to PARITY if PARITY≠0, else STOP.
  - PARITY: at s=15, sample the parity bit and compare it with the XOR of the data bits (even) or its inverse (odd).
  - STOP: at s=SB_TICK-1, sample rx, then → IDLE.
    - Stop sample 0: set frame_err.
    - Parity mismatch: set parity_err.
    - Either error: the word is discarded.
    - Otherwise the word is written to the RX FIFO. If the FIFO is full, the word is dropped and overrun is set.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - In IDLE with tx_empty=0: pop the TX FIFO head into the shift register, compute the parity bit, → START.
  - Bits per state: START drives 0; DATA drives the shift-register LSB; PARITY drives the parity bit; STOP drives 1.
  - Each state lasts 16 ticks, except STOP, which lasts SB_TICK ticks, then → IDLE.
  - Back-to-back frames have no idle gap beyond the one-clock IDLE pass.
- FIFOs: circular buffers with ADDR_W+1-bit pointers; full/empty come from pointer compare.
  - Write when full and read when empty are ignored; state is unchanged.
  - Simultaneous read and write: both are performed, including when full. When empty, only the write is performed.
  - count = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)).
- Error flags set on the event and hold until clr_err=1. If clr_err coincides with a new error, the flag is set.
- Reset asserted mid-frame: tx=1 immediately (asynchronous), FIFO contents are lost, both FSMs return to IDLE.

## Timing
- tick period = Final_Value+1 clocks; one bit = 16 ticks.
- TX frame = (1+DBIT+(PARITY≠0))·16 + SB_TICK ticks.
- TX start: the FSM pops in the first clock tx_empty=0 is seen in IDLE. tx falls in the following clock. tx_busy rises in the same clock tx falls.
- RX write: the word enters the FIFO on the clock after the stop-bit sample tick. rx_empty falls one clock later, and r_data is valid in the same clock.
- Sampling point is mid-bit: start bit plus 8 ticks, then every 16 ticks.
- FIFO write/read and count updates complete in one clock. The r_data head updates the clock after rd_uart.

## Test plan
- DBIT=8, PARITY=0, Final_Value=1, tx looped to rx; wr_uart with 0xA5 → tx low for 32 clocks, then 10 bits LSB first; rx_empty falls after the frame; r_data=0xA5; rx_count=1.
- PARITY=1, 0x03 sent with parity bit 1 (wrong) → parity_err=1, rx_empty stays 1; then clr_err → parity_err=0; then a correct frame with parity 0 is received.
- Stop bit driven 0 on 0x55 → frame_err=1, no word written; a following good 0x55 frame is received normally.
- ADDR_W=2, 5 looped frames 0x01..0x05 with no reads → rx_full=1, overrun=1, reads return 0x01..0x04, then rx_empty=1.
- ADDR_W=2, 6 back-to-back wr_uart (0x10..0x15) → tx_full=1 after the fifth write, 0x15 dropped; tx emits 0x10..0x14; tx_empty and tx_busy=0 at the end.
- rx low for 4 ticks only → no word written, no errors set. reset_n low mid-DATA → tx=1 in the same clock, all counts 0, flags 0.

Source files
------------

// File: rtl/uart_core_p.sv
// Purpose: parametrised UART core: baud ticks, 16x-oversampled RX, TX, two FWFT FIFOs, sticky error flags.
// Latency: tx falls 2 clocks after wr_uart on an idle core; a received word is readable 2 clocks after its stop sample.
// Backpressure: wr_uart into a full TX FIFO is dropped; an RX word arriving at a full FIFO is dropped and sets overrun.
module uart_core_p #(
  parameter int DBIT    = 8,
  parameter int PARITY  = 0,
  parameter int SB_TICK = 16,
  parameter int ADDR_W  = 4,
  parameter int DIV_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  Final_Value,
  input  logic              rx,
  output logic              tx,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              tx_empty,
  output logic              tx_full,
  output logic [ADDR_W:0]   rx_count,
  output logic [ADDR_W:0]   tx_count,
  output logic              tx_busy,
  input  logic              clr_err,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);
  localparam int         DEPTH  = 2**ADDR_W;
  localparam logic [4:0] S_STOP = 5'(SB_TICK-1);
  localparam logic [3:0] N_LAST = 4'(DBIT-1);
  localparam logic       ODD    = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} st_t;

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] cnt_q, lim_q;
  logic             tick;

  // At count 0 the live divisor is used and captured, so a new value only applies from the next period.
  assign tick = (cnt_q == '0) ? (Final_Value == '0) : (cnt_q == lim_q);

  // Free-running tick counter, wraps on tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (cnt_q == '0) lim_q <= Final_Value;
    end
  end

  // ---------------- rx synchroniser ----------------
  logic rx_s1_q, rx_s2_q;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // ---------------- receiver ----------------
  st_t             rst_q, rst_d;
  logic [4:0]      rs_q, rs_d;
  logic [3:0]      rn_q, rn_d;
  logic [DBIT-1:0] rb_q, rb_d;
  logic            rpok_q, rpok_d;
  logic            rx_push_q, rx_push_d;
  logic            set_pe, set_fe, set_ov;

  // RX next state: start-bit glitch filter, mid-bit sampling, parity/stop evaluation.
  always_comb begin
    rst_d = rst_q; rs_d = rs_q; rn_d = rn_q; rb_d = rb_q; rpok_d = rpok_q;
    rx_push_d = 1'b0; set_pe = 1'b0; set_fe = 1'b0;
    unique case (rst_q)
      IDLE: if (!rx_s2_q) begin
        rst_d = START;
        rs_d  = '0;
      end
      START: if (tick) begin
        if (rs_q == 5'd7) begin
          rs_d   = '0;
          rn_d   = '0;
          rpok_d = 1'b1;
          rst_d  = rx_s2_q ? IDLE : DATA;
        end else rs_d = rs_q + 1'b1;
      end
      DATA: if (tick) begin
        if (rs_q == 5'd15) begin
          rs_d = '0;
          rb_d = {rx_s2_q, rb_q[DBIT-1:1]};
          if (rn_q == N_LAST) rst_d = (PARITY != 0) ? PAR : STOP;
          else                rn_d  = rn_q + 1'b1;
        end else rs_d = rs_q + 1'b1;
      end
      PAR: if (tick) begin
        if (rs_q == 5'd15) begin
          rs_d   = '0;
          rpok_d = (rx_s2_q == ((^rb_q) ^ ODD));
          rst_d  = STOP;
        end else rs_d = rs_q + 1'b1;
      end
      STOP: if (tick) begin
        if (rs_q == S_STOP) begin
          rst_d     = IDLE;
          set_fe    = !rx_s2_q;
          set_pe    = !rpok_q;
          rx_push_d = rx_s2_q && rpok_q;
        end else rs_d = rs_q + 1'b1;
      end
      default: rst_d = IDLE;
    endcase
  end

  // RX state registers; the FIFO write is registered one clock behind the stop sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_q <= IDLE; rs_q <= '0; rn_q <= '0; rb_q <= '0; rpok_q <= 1'b1; rx_push_q <= 1'b0;
    end else begin
      rst_q <= rst_d; rs_q <= rs_d; rn_q <= rn_d; rb_q <= rb_d; rpok_q <= rpok_d; rx_push_q <= rx_push_d;
    end
  end

  // ---------------- FIFOs (FWFT, extra pointer bit tells full from empty) ----------------
  logic [DBIT-1:0] rmem_q [DEPTH];
  logic [DBIT-1:0] tmem_q [DEPTH];
  logic [ADDR_W:0] rwp_q, rrp_q, twp_q, trp_q;
  logic            rx_do_wr, rx_do_rd, tx_do_wr, tx_pop;
  logic [DBIT-1:0] tx_head;

  assign rx_empty = (rwp_q == rrp_q);
  assign rx_full  = (rwp_q[ADDR_W] != rrp_q[ADDR_W]) && (rwp_q[ADDR_W-1:0] == rrp_q[ADDR_W-1:0]);
  assign rx_count = rwp_q - rrp_q;
  assign rx_do_rd = rd_uart && !rx_empty;
  assign rx_do_wr = rx_push_q && (!rx_full || rx_do_rd);
  assign set_ov   = rx_push_q && rx_full && !rx_do_rd;
  assign r_data   = rx_empty ? '0 : rmem_q[rrp_q[ADDR_W-1:0]];

  assign tx_empty = (twp_q == trp_q);
  assign tx_full  = (twp_q[ADDR_W] != trp_q[ADDR_W]) && (twp_q[ADDR_W-1:0] == trp_q[ADDR_W-1:0]);
  assign tx_count = twp_q - trp_q;
  assign tx_do_wr = wr_uart && (!tx_full || tx_pop);
  assign tx_head  = tmem_q[trp_q[ADDR_W-1:0]];

  // FIFO pointers; a write into a full FIFO is accepted only alongside a read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rwp_q <= '0; rrp_q <= '0; twp_q <= '0; trp_q <= '0;
    end else begin
      if (rx_do_wr) rwp_q <= rwp_q + 1'b1;
      if (rx_do_rd) rrp_q <= rrp_q + 1'b1;
      if (tx_do_wr) twp_q <= twp_q + 1'b1;
      if (tx_pop)   trp_q <= trp_q + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (rx_do_wr) rmem_q[rwp_q[ADDR_W-1:0]] <= rb_q;
    if (tx_do_wr) tmem_q[twp_q[ADDR_W-1:0]] <= w_data;
  end

  // ---------------- sticky error flags ----------------
  logic pe_q, fe_q, ov_q;

  // A new error wins over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_q <= 1'b0; fe_q <= 1'b0; ov_q <= 1'b0;
    end else begin
      pe_q <= set_pe | (pe_q & ~clr_err);
      fe_q <= set_fe | (fe_q & ~clr_err);
      ov_q <= set_ov | (ov_q & ~clr_err);
    end
  end

  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;

  // ---------------- transmitter ----------------
  st_t             tst_q, tst_d;
  logic [4:0]      ts_q, ts_d;
  logic [3:0]      tn_q, tn_d;
  logic [DBIT-1:0] tb_q, tb_d;
  logic            tpar_q, tpar_d;
  logic            tx_q, tx_d;

  // TX next state; the line level is derived from the next state so tx changes with the state.
  always_comb begin
    tst_d = tst_q; ts_d = ts_q; tn_d = tn_q; tb_d = tb_q; tpar_d = tpar_q;
    tx_pop = 1'b0;
    tx_d   = 1'b1;
    unique case (tst_q)
      IDLE: if (!tx_empty) begin
        tx_pop = 1'b1;
        tb_d   = tx_head;
        tpar_d = (^tx_head) ^ ODD;
        ts_d   = '0;
        tst_d  = START;
      end
      START: if (tick) begin
        if (ts_q == 5'd15) begin
          ts_d  = '0;
          tn_d  = '0;
          tst_d = DATA;
        end else ts_d = ts_q + 1'b1;
      end
      DATA: if (tick) begin
        if (ts_q == 5'd15) begin
          ts_d = '0;
          tb_d = tb_q >> 1;
          if (tn_q == N_LAST) tst_d = (PARITY != 0) ? PAR : STOP;
          else                tn_d  = tn_q + 1'b1;
        end else ts_d = ts_q + 1'b1;
      end
      PAR: if (tick) begin
        if (ts_q == 5'd15) begin
          ts_d  = '0;
          tst_d = STOP;
        end else ts_d = ts_q + 1'b1;
      end
      STOP: if (tick) begin
        if (ts_q == S_STOP) tst_d = IDLE;
        else                ts_d  = ts_q + 1'b1;
      end
      default: tst_d = IDLE;
    endcase
    case (tst_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tb_d[0];
      PAR:     tx_d = tpar_d;
      default: tx_d = 1'b1;
    endcase
  end

  // TX state registers; tx resets high asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tst_q <= IDLE; ts_q <= '0; tn_q <= '0; tb_q <= '0; tpar_q <= 1'b0; tx_q <= 1'b1;
    end else begin
      tst_q <= tst_d; ts_q <= ts_d; tn_q <= tn_d; tb_q <= tb_d; tpar_q <= tpar_d; tx_q <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tst_q != IDLE);

endmodule

// File: tb/tb_uart_core_p.sv
// Purpose: self-checking bench for uart_core_p (8 data bits, even parity, 4-deep FIFOs, Final_Value=1).
// Latency: one serial bit = 16 ticks * 2 clocks = 32 clocks; all sampling on the falling clock edge.
// Backpressure: bench models FIFO depth, drops and sticky flags from the frame-level rules.
module tb_uart_core_p;
  localparam int DBIT = 8, PARITY = 1, SB_TICK = 16, ADDR_W = 2, DIV_W = 16;
  localparam int DEPTH = 4;
  localparam int BITC  = 32;

  logic              clk = 1'b0, reset_n = 1'b0;
  logic [DIV_W-1:0]  Final_Value = 16'd1;
  logic              rx, tx, wr_uart = 1'b0, rd_uart = 1'b0, clr_err = 1'b0;
  logic [DBIT-1:0]   w_data = '0, r_data;
  logic              rx_empty, rx_full, tx_empty, tx_full, tx_busy;
  logic [ADDR_W:0]   rx_count, tx_count;
  logic              parity_err, frame_err, overrun;
  logic              loop = 1'b0, rx_drv = 1'b1;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_core_p #(.DBIT(DBIT), .PARITY(PARITY), .SB_TICK(SB_TICK), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .Final_Value(Final_Value), .rx(rx), .tx(tx),
    .wr_uart(wr_uart), .w_data(w_data), .rd_uart(rd_uart), .r_data(r_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .tx_empty(tx_empty), .tx_full(tx_full),
    .rx_count(rx_count), .tx_count(tx_count), .tx_busy(tx_busy), .clr_err(clr_err),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  int          n_chk = 0, n_fail = 0;
  logic [7:0]  exp_rx[$];
  logic [7:0]  exp_tx[$];
  logic [9:0]  mon_q[$];   // {stop, parity, data} as seen on tx
  logic        exp_pe = 1'b0, exp_fe = 1'b0, exp_ov = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a good word is stored unless the 4-deep FIFO already holds 4 words.
  task automatic model_rx_word(input logic [7:0] d);
    if (exp_rx.size() == DEPTH) exp_ov = 1'b1;
    else exp_rx.push_back(d);
  endtask

  // Decode every frame seen on tx at mid-bit.
  initial begin
    logic [9:0] f;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (BITC/2) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
          repeat (BITC) @(negedge clk);
          f[b] = tx;
        end
        mon_q.push_back(f);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (mon_q.size() < n && t < n*400 + 400) begin
      @(negedge clk);
      t++;
    end
    check("tx_frames_seen", mon_q.size(), n);
    repeat (40) @(negedge clk);
  endtask

  task automatic check_tx();
    logic [9:0] f;
    logic [7:0] e;
    check("tx_nframes", mon_q.size(), exp_tx.size());
    while (mon_q.size() > 0 && exp_tx.size() > 0) begin
      f = mon_q.pop_front();
      e = exp_tx.pop_front();
      check("tx_data", f[7:0], e);
      check("tx_parity", f[8], ^e);
      check("tx_stop", f[9], 1);
    end
    mon_q.delete();
    exp_tx.delete();
  endtask

  task automatic check_flags();
    check("parity_err", parity_err, exp_pe);
    check("frame_err", frame_err, exp_fe);
    check("overrun", overrun, exp_ov);
    check("rx_count", rx_count, exp_rx.size());
  endtask

  task automatic read_all();
    logic [7:0] e;
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      check("rx_empty_before_read", rx_empty, 0);
      check("r_data", r_data, e);
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
    end
    check("rx_empty_after_reads", rx_empty, 1);
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_pe = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0;
  endtask

  // Bit-bang one frame on rx; a bad stop bit is held low only past the sampling point.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
    rx_drv = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BITC) @(negedge clk);
    end
    rx_drv = pbit;
    repeat (BITC) @(negedge clk);
    rx_drv = sbit;
    repeat (26) @(negedge clk);
    rx_drv = 1'b1;
    repeat (6 + 2*BITC) @(negedge clk);
    if (!sbit) exp_fe = 1'b1;
    if (pbit != ^d) exp_pe = 1'b1;
    if (sbit && pbit == ^d) model_rx_word(d);
  endtask

  task automatic burst_write(input int k, input logic rand_data, input logic [7:0] base);
    logic [7:0] d;
    for (int j = 0; j < k; j++) begin
      d = rand_data ? 8'($urandom) : base + 8'(j);
      exp_tx.push_back(d);
      model_rx_word(d);
      wr_uart = 1'b1;
      w_data  = d;
      @(negedge clk);
    end
    wr_uart = 1'b0;
  endtask

  initial begin
    int         low, k;
    logic [7:0] d;
    logic       p, s;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_empties", {rx_empty, tx_empty}, 2'b11);
    check("rst_fulls", {rx_full, tx_full}, 2'b00);
    check("rst_flags", {parity_err, frame_err, overrun}, 3'b000);
    check("rst_r_data", r_data, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // single looped frame 0xA5: pop latency, start-bit length, reception
    loop = 1'b1;
    burst_write(1, 1'b0, 8'hA5);
    check("tx_before_pop", tx, 1);
    check("busy_before_pop", tx_busy, 0);
    @(negedge clk);
    check("tx_fall", tx, 0);
    check("busy_rise", tx_busy, 1);
    low = 0;
    while (tx === 1'b0 && low < 100) begin
      @(negedge clk);
      low++;
    end
    check("start_bit_len_31_32", (low >= 31 && low <= 32), 1);
    wait_frames(1);
    check_flags();
    read_all();
    check_tx();

    // random looped bursts that fit the FIFOs
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, 4);
      burst_write(k, 1'b1, 8'h00);
      wait_frames(k);
      check_flags();
      read_all();
      check_tx();
    end

    // directly driven frames: directed parity/framing cases, then random corruption
    loop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: begin d = 8'h03; p = 1'b1; s = 1'b1; end
        1: begin
          clear_err();
          check("parity_err_cleared", parity_err, 0);
          d = 8'h03; p = 1'b0; s = 1'b1;
        end
        2: begin d = 8'h55; p = 1'b0; s = 1'b0; end
        3: begin d = 8'h55; p = 1'b0; s = 1'b1; end
        default: begin
          d = 8'($urandom);
          p = (^d) ^ ($urandom_range(0, 3) == 0);
          s = ($urandom_range(0, 3) != 0);
        end
      endcase
      send_frame(d, p, s);
      check_flags();
      if (i == 0) check("rx_empty_after_bad_parity", rx_empty, 1);
      if (i >= 3 && $urandom_range(0, 1) == 1) clear_err();
      if (i == 3 || $urandom_range(0, 2) == 0) read_all();
    end

    // start-bit glitch of 4 ticks is ignored
    read_all();
    clear_err();
    rx_drv = 1'b0;
    repeat (8) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2*BITC) @(negedge clk);
    check_flags();

    // overrun: five looped frames, no reads
    loop = 1'b1;
    burst_write(5, 1'b0, 8'h01);
    wait_frames(5);
    check("rx_full_overrun", rx_full, 1);
    check_flags();
    read_all();
    check_tx();
    clear_err();

    // TX FIFO full: six back-to-back writes, the sixth is dropped
    loop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        check("tx_full_after_5", tx_full, 1);
        check("tx_count_after_5", tx_count, DEPTH);
      end
      if (i < DEPTH + 1) exp_tx.push_back(8'h10 + 8'(i));
      wr_uart = 1'b1;
      w_data  = 8'h10 + 8'(i);
      @(negedge clk);
    end
    wr_uart = 1'b0;
    wait_frames(5);
    check("tx_empty_end", tx_empty, 1);
    check("tx_busy_end", tx_busy, 0);
    check_tx();

    // reset in the middle of a frame
    send_frame(8'h55, 1'b0, 1'b0);
    check_flags();
    loop = 1'b1;
    wr_uart = 1'b1;
    w_data  = 8'h00;
    @(negedge clk);
    wr_uart = 1'b0;
    repeat (100) @(negedge clk);
    check("tx_low_mid_frame", tx, 0);
    reset_n = 1'b0;
    #1;
    check("tx_async_reset", tx, 1);
    @(negedge clk);
    check("rst2_counts", {rx_count, tx_count}, 0);
    check("rst2_flags", {parity_err, frame_err, overrun}, 3'b000);
    check("rst2_busy", tx_busy, 0);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    check("rst2_no_rx_word", rx_count, 0);
    mon_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
